// File: rtl/mips_cpu_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mips_cpu_mem_arbiter_if
//
// Avalon-style memory-mapped bus between the CPU memory arbiter (master) and
// the unified memory / system bus (slave).
//
// Signals:
//   avm_address      word-aligned byte address          master -> slave
//   avm_read         read strobe                        master -> slave
//   avm_write        write strobe                       master -> slave
//   avm_writedata    write data                         master -> slave
//   avm_byteenable   byte lanes                         master -> slave
//   avm_waitrequest  stall, strobe must be held         slave  -> master
//   avm_readdata     read data, valid when not stalled  slave  -> master
// ----------------------------------------------------------------------------
interface mips_cpu_mem_arbiter_if;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// mips_cpu_mem_arbiter
//
// Shares one Avalon-style master port between the instruction-fetch requester
// and the data (load/store) requester. One access is in flight at a time:
//   IDLE -> BUSY (strobe on the bus, honouring waitrequest) -> DONE (ack pulse)
// Simultaneous requests are granted round robin; after reset the data side
// wins the first tie. A hung access is aborted after TIMEOUT_CYCLES
// waitrequest cycles and completes with err=1 (reads return zero).
//
// Parameters:
//   TIMEOUT_CYCLES  waitrequest cycles tolerated before abort, 0 = never abort
//   CNT_W           timeout counter width, must be able to hold TIMEOUT_CYCLES
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_req/i_addr                    fetch request (held until i_ack), address
//   i_ack/i_rdata                   fetch done pulse, fetched word
//   d_req/d_write/d_addr/d_wdata/   data request (held until d_ack), store
//   d_byteenable                    flag, address, store data, byte lanes
//   d_ack/d_rdata                   data done pulse, load data
//   err                             qualifies i_ack/d_ack: access timed out
//   avm                             bus master port (see interface file)
// ----------------------------------------------------------------------------
module mips_cpu_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   i_req,
    input  logic [31:0]            i_addr,
    output logic                   i_ack,
    output logic [31:0]            i_rdata,

    input  logic                   d_req,
    input  logic                   d_write,
    input  logic [31:0]            d_addr,
    input  logic [31:0]            d_wdata,
    input  logic [3:0]             d_byteenable,
    output logic                   d_ack,
    output logic [31:0]            d_rdata,

    output logic                   err,

    mips_cpu_mem_arbiter_if.master avm
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam bit              TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    // Counter value seen on the last tolerated wait cycle; the abort happens
    // on that edge so the strobe is held for exactly TIMEOUT_CYCLES stalls.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Control state
    state_t            state_q, state_d;
    owner_t            owner_q;
    owner_t            last_grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    // Latched copy of the granted request
    logic [29:0]       word_addr_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    // Decode helpers
    logic              grant_valid;
    owner_t            grant_owner;
    logic              timed_out;
    logic              finish;

    // Byte-offset bits never reach the bus: the address is word aligned.
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    // ------------------------------------------------------------------------
    // Arbitration: single requester wins outright, a tie goes to the side
    // that did not win last time.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        grant_owner = OWN_I;
        grant_valid = i_req | d_req;
        if (i_req && d_req) begin
            if (last_grant_q == OWN_I) begin
                grant_owner = OWN_D;
            end else begin
                grant_owner = OWN_I;
            end
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

    assign timed_out = TIMEOUT_EN && avm.avm_waitrequest && (cnt_q == TIMEOUT_LAST);
    assign finish    = !avm.avm_waitrequest || timed_out;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_valid) state_d = S_BUSY;
            S_BUSY:  if (finish)      state_d = S_DONE;
            S_DONE:                   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (grant_valid) begin
                        owner_q      <= grant_owner;
                        last_grant_q <= grant_owner;
                    end
                end
                S_BUSY: begin
                    if (finish) begin
                        err_q <= timed_out;
                        // Stores never disturb the requester's read data.
                        if (!write_q) begin
                            if (owner_q == OWN_D) begin
                                d_rdata_q <= timed_out ? 32'h0 : avm.avm_readdata;
                            end else begin
                                i_rdata_q <= timed_out ? 32'h0 : avm.avm_readdata;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // err only qualifies the ack cycle.
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Request latch. Requester inputs may change once granted; the bus is
    // driven from this copy only.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: pure datapath registers are left out of reset; they are always
        // loaded on grant before anything reads them.
        if (state_q == S_IDLE && grant_valid) begin
            if (grant_owner == OWN_D) begin
                word_addr_q <= d_addr[31:2];
                write_q     <= d_write;
                wdata_q     <= d_wdata;
                be_q        <= d_byteenable;
            end else begin
                word_addr_q <= i_addr[31:2];
                write_q     <= 1'b0;
                wdata_q     <= 32'h0;
                be_q        <= 4'b1111;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state and the latched request only.
    // ------------------------------------------------------------------------
    assign avm.avm_address    = {word_addr_q, 2'b00};
    assign avm.avm_read       = (state_q == S_BUSY) && !write_q;
    assign avm.avm_write      = (state_q == S_BUSY) &&  write_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = be_q;

    assign i_ack   = (state_q == S_DONE) && (owner_q == OWN_I);
    assign d_ack   = (state_q == S_DONE) && (owner_q == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_one_strobe: assert property (@(posedge clk) disable iff (reset)
        !(avm.avm_read && avm.avm_write));
    a_one_ack: assert property (@(posedge clk) disable iff (reset)
        !(i_ack && d_ack));

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mips_cpu_mem_arbiter
//
// Directed bench for the CPU memory arbiter (TIMEOUT_CYCLES = 4). Each access
// pushes its expected bus transfer and its expected completion into queues;
// a bus monitor and an ack monitor pop and compare whenever the DUT strobes
// the bus or pulses an ack. A small bus slave returns word_at(address) and
// stalls for wait_cycles strobe cycles.
// ----------------------------------------------------------------------------
module tb_mips_cpu_mem_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;

    mips_cpu_mem_arbiter_if bus ();

    mips_cpu_mem_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_byteenable (d_byteenable),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .err          (err),
        .avm          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          strobes;
    } bus_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } cmp_t;

    bus_t bus_q[$];
    cmp_t cmp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Bus slave
    // ------------------------------------------------------------------------
    int wait_cycles = 0;
    int scnt        = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h8C01_0004;
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(negedge clk) begin
        if (bus.avm_read || bus.avm_write) begin
            bus.avm_waitrequest = (scnt < wait_cycles);
            scnt++;
        end else begin
            scnt = 0;
            bus.avm_waitrequest = 1'b0;
        end
        bus.avm_readdata = word_at(bus.avm_address);
    end

    // ------------------------------------------------------------------------
    // Bus monitor: every strobe cycle must show the latched request; the
    // strobe must last the expected number of cycles.
    // ------------------------------------------------------------------------
    bus_t cur;
    bit   in_strobe  = 1'b0;
    int   strobe_cnt = 0;

    always @(negedge clk) begin
        if (bus.avm_read || bus.avm_write) begin
            if (!in_strobe) begin
                in_strobe  = 1'b1;
                strobe_cnt = 0;
                n_checks++;
                if (bus_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL bus_unexpected: strobe at addr 0x%08h, expected no access",
                             bus.avm_address);
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            strobe_cnt++;
            check("bus_addr",  bus.avm_address, cur.addr);
            check("bus_write", bus.avm_write, cur.write);
            check("bus_read",  bus.avm_read, !cur.write);
            check("bus_be",    bus.avm_byteenable, cur.be);
            if (cur.write) check("bus_wdata", bus.avm_writedata, cur.wdata);
        end else if (in_strobe) begin
            in_strobe = 1'b0;
            check("bus_strobe_len", strobe_cnt, cur.strobes);
        end
    end

    // ------------------------------------------------------------------------
    // Ack monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        cmp_t e;
        if (i_ack || d_ack) begin
            check("ack_exclusive", i_ack & d_ack, 1'b0);
            n_checks++;
            if (cmp_q.size() == 0) begin
                n_errors++;
                $display("FAIL ack_unexpected: i_ack=%0b d_ack=%0b, expected no ack", i_ack, d_ack);
            end else begin
                e = cmp_q.pop_front();
                check("ack_owner", d_ack, e.is_data);
                if (e.is_data) check("d_rdata", d_rdata, e.rdata);
                else           check("i_rdata", i_rdata, e.rdata);
                check("ack_err", err, e.err);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------------
    task automatic wait_ack(input bit is_data, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(is_data ? d_ack : i_ack) && lat < 64);
    endtask

    // One access from idle. perturb scribbles over the data-side inputs once
    // the request is granted; the bus must keep showing the originals.
    task automatic do_access(input bit is_data, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be, input int waits,
                             input logic [31:0] exp_baddr, input logic [3:0] exp_be,
                             input logic [31:0] exp_rdata, input bit exp_err,
                             input int exp_strobes, input int exp_lat, input bit perturb,
                             input string name);
        int  lat;
        bit  got;
        bus_q.push_back('{exp_baddr, wr, wdata, exp_be, exp_strobes});
        cmp_q.push_back('{is_data, exp_rdata, exp_err});
        wait_cycles = waits;
        if (is_data) begin
            d_write = wr; d_addr = addr; d_wdata = wdata; d_byteenable = be; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 64) begin
            @(negedge clk);
            lat++;
            if (perturb && lat == 1) begin
                d_addr = ~addr; d_wdata = ~wdata; d_byteenable = ~be; d_write = ~wr;
            end
            got = is_data ? d_ack : i_ack;
        end
        check(name, lat, exp_lat);
        i_req = 1'b0;
        d_req = 1'b0;
        d_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int lat;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;

        repeat (3) @(negedge clk);
        check("rst_i_ack",   i_ack, 1'b0);
        check("rst_d_ack",   d_ack, 1'b0);
        check("rst_err",     err, 1'b0);
        check("rst_read",    bus.avm_read, 1'b0);
        check("rst_write",   bus.avm_write, 1'b0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Ties, three rounds: data wins first after reset, then alternate.
        for (int r = 0; r < 3; r++) begin
            logic [31:0] da;
            logic [31:0] ia;
            da = 32'h0000_0200 + 32'(r * 16);
            ia = 32'h0000_0400 + 32'(r * 16);
            bus_q.push_back('{da, 1'b0, 32'h0, 4'b0110, 1});
            bus_q.push_back('{ia, 1'b0, 32'h0, 4'b1111, 1});
            cmp_q.push_back('{1'b1, 32'hA5A5_0200 + 32'(r * 16), 1'b0});
            cmp_q.push_back('{1'b0, 32'hA5A5_0400 + 32'(r * 16), 1'b0});
            wait_cycles = 0;
            d_addr = da; d_write = 1'b0; d_byteenable = 4'b0110; d_wdata = 32'hFFFF_0000;
            i_addr = ia;
            d_req = 1'b1;
            i_req = 1'b1;
            wait_ack(1'b1, lat);
            check("tie_d_latency", lat, 2);
            d_req = 1'b0;
            wait_ack(1'b0, lat);
            check("tie_i_latency", lat, 3);
            i_req = 1'b0;
            @(negedge clk);
        end

        // Boot fetch, unaligned address, no stalls.
        do_access(1'b0, 1'b0, 32'hBFC0_0002, 32'h0, 4'b0000, 0,
                  32'hBFC0_0000, 4'b1111, 32'h8C01_0004, 1'b0, 1, 2, 1'b0, "fetch_latency");

        // Store with three stalls; d_rdata keeps the last load value.
        do_access(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 3,
                  32'h0000_0100, 4'b0011, 32'hA5A5_0220, 1'b0, 4, 5, 1'b0, "store_latency");

        // Load with a stuck slave: aborted after four stalls, err, zero data.
        do_access(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'b1111, 1000,
                  32'h0000_0600, 4'b1111, 32'h0000_0000, 1'b1, 4, 5, 1'b0, "timeout_latency");

        // Next load after the abort is serviced normally.
        do_access(1'b1, 1'b0, 32'h0000_0604, 32'h0, 4'b1111, 1,
                  32'h0000_0604, 4'b1111, 32'hA5A5_0604, 1'b0, 2, 3, 1'b0, "post_timeout_latency");

        // Requester inputs scribbled while busy.
        do_access(1'b1, 1'b1, 32'h0000_0303, 32'h1234_5678, 4'b1100, 2,
                  32'h0000_0300, 4'b1100, 32'hA5A5_0604, 1'b0, 3, 4, 1'b1, "perturb_latency");

        // Reset in the middle of a stalled fetch: no ack, request re-granted.
        bus_q.push_back('{32'h0000_0500, 1'b0, 32'h0, 4'b1111, 2});
        wait_cycles = 1000;
        i_addr = 32'h0000_0500;
        i_req = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_read",    bus.avm_read, 1'b0);
        check("midrst_i_ack",   i_ack, 1'b0);
        check("midrst_d_ack",   d_ack, 1'b0);
        check("midrst_err",     err, 1'b0);
        check("midrst_i_rdata", i_rdata, 32'h0);
        check("midrst_d_rdata", d_rdata, 32'h0);
        bus_q.push_back('{32'h0000_0500, 1'b0, 32'h0, 4'b1111, 1});
        cmp_q.push_back('{1'b0, 32'hA5A5_0500, 1'b0});
        wait_cycles = 0;
        reset = 1'b0;
        wait_ack(1'b0, lat);
        check("regrant_latency", lat, 2);
        i_req = 1'b0;

        repeat (4) @(negedge clk);
        check("bus_q_drained", bus_q.size(), 0);
        check("cmp_q_drained", cmp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
